receptor_serie: RTL and testbench
=================================

# receptor_serie

Serial-to-parallel frame receiver. It is the receiving end of the 8-bit shift-register serial link: a single-bit line carrying start/data/stop frames arrives qualified by a bit strobe. The receiver assembles each frame into an 8-bit word and presents it on a valid/ready parallel port. It sits between the serial line front-end and the word consumer, and reports framing, overrun and (optionally) parity errors.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame. The design and test plan are fixed at 8.

Ports:
- `clock`  in  1: single clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `serial_in`  in  1: serial line. Idles high.
- `bit_valid`  in  1: strobe. `serial_in` is sampled only on cycles where `bit_valid` is 1.
- `dir`  in  1: bit order. 0 = MSB first (data enters at bit 0 and shifts left). 1 = LSB first (data enters at bit 7 and shifts right). Sampled with the start bit.
- `word_ready`  in  1: consumer accepts the word this cycle.
- `Q`  out  8: received word. `Q[7]` is the MSB.
- `word_valid`  out  1: `Q` holds an unconsumed word.
- `parity_error`  out  1: parity flag for the word on `Q`. Valid while `word_valid` is 1.
- `frame_error`  out  1: one-cycle pulse when a frame's stop bit is 0.
- `overrun`  out  1: one-cycle pulse when a completed word is dropped.
- `busy`  out  1: a frame is in progress (state is not IDLE).

## Operation
- Internal 8-bit shift register `sh` and a bit counter `cnt` (0..7). The output register `Q` is separate from `sh`, so reception continues while a word is held on `Q`.
- FSM states and transitions. All transitions happen only on cycles with `bit_valid` = 1.
  - IDLE: a sample of `serial_in` = 0 is the start bit. Latch `dir`, clear `cnt`, go to DATA. A sample of 1 stays in IDLE.
  - DATA: shift the sample into `sh` according to the latched `dir`, increment `cnt`. After the 8th bit (`cnt` = 7), go to PAR if `PARITY_CHECK_EN` is defined, otherwise go to STOP.
  - PAR: compare the sample with even parity over `sh`, then go to STOP.
  - STOP: sample = 1 completes the frame. Sample = 0 pulses `frame_error`, discards the word, and returns to IDLE. Both cases return to IDLE.
- On a completed frame:
  - If `word_valid` = 0, or `word_ready` = 1 in the same cycle: `Q` ← `sh`, `parity_error` ← the computed mismatch, `word_valid` ← 1.
  - Otherwise the new word is discarded, `overrun` pulses, and `Q`/`word_valid` are unchanged.
- Handshake: when `word_valid` and `word_ready` are both 1, the word is consumed and `word_valid` clears next cycle, unless a new word loads in that same cycle.
- `dir` changes mid-frame are ignored.
- A start bit may arrive on the first `bit_valid` after the stop bit. No idle gap is required.

## Timing
- Reset values: `Q` = 8'hFF, `word_valid` = 0, `parity_error` = 0, `frame_error` = 0, `overrun` = 0, `busy` = 0. FSM is in IDLE, `sh` = 8'hFF, `cnt` = 0.
- Reset asserted mid-frame discards the partial word and returns to IDLE next cycle. A held `Q` word is also discarded.
- Latency: `word_valid` rises on the clock edge after the edge that samples the stop bit.
- `frame_error` and `overrun` are asserted for exactly one cycle, on that same cycle.
- `busy` rises the cycle after the start-bit sample and falls the cycle after the stop-bit sample.
- Minimum frame length is 10 strobes (11 with parity). Throughput is one word per frame with back-to-back strobes.
- `bit_valid` = 0 cycles freeze the FSM, `sh` and `cnt`. Gaps of any length are legal.

## Configuration
- `PARITY_CHECK_EN` defined:
  - Frames carry an even-parity bit between data bit 7 and the stop bit. The PAR state is present.
  - `parity_error` is 1 when the received parity bit differs from the XOR of the 8 data bits.
  - The word is still delivered when parity fails.
- `PARITY_CHECK_EN` undefined:
  - The PAR state is absent and frames are 10 bits.
  - `parity_error` is constant 0.

## Test plan
- Reset, then a frame with `dir` = 0, data bits 1,0,1,0,0,1,0,1 and stop 1, all strobes back-to-back (no parity) -> `Q` = 8'hA5 and `word_valid` = 1 one cycle after the stop-bit sample.
- The same bit sequence with `dir` = 1 -> `Q` = 8'hA5 (the first received bit lands in `Q[0]`). `word_ready` = 1 for one cycle -> `word_valid` = 0 next cycle.
- A frame with stop bit 0 -> `frame_error` is high for one cycle, `word_valid` stays 0, FSM returns to IDLE and accepts the next frame normally.
- Receive 8'h3C, hold `word_ready` = 0, receive 8'hC3 -> `overrun` pulses, `Q` stays 8'h3C. Repeat with `word_ready` = 1 on the completion cycle of the second frame -> `Q` = 8'hC3, no `overrun`.
- Random `bit_valid` gaps of 0–5 cycles inside a frame -> same `Q` as the back-to-back case. Assert `reset` after bit 4 -> `busy` = 0 and `Q` = 8'hFF next cycle, and the following frame is received correctly.
- `PARITY_CHECK_EN` defined: 8'h01 with parity bit 1 -> `parity_error` = 0. The same data with parity bit 0 -> `Q` = 8'h01, `word_valid` = 1, `parity_error` = 1.

Source files
------------

// File: rtl/receptor_serie_if.sv
// receptor_serie_if: serial-line and parallel-word port bundle of receptor_serie.
// The master side is the line front-end plus the word consumer. The slave side
// is the receiver.
// Handshake: a word moves when word_valid and word_ready are both 1 on a rising
// clock edge. word_valid stays high with Q stable until that happens.
// state_dbg mirrors the receiver FSM state. Encoding: 0 IDLE, 1 DATA, 2 PAR, 3 STOP.
`timescale 1ns/1ps
interface receptor_serie_if #(parameter int DATA_W = 8);
  logic              serial_in;
  logic              bit_valid;
  logic              dir;
  logic              word_ready;
  logic [DATA_W-1:0] Q;
  logic              word_valid;
  logic              parity_error;
  logic              frame_error;
  logic              overrun;
  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    output serial_in, bit_valid, dir, word_ready,
    input  Q, word_valid, parity_error, frame_error, overrun, busy, state_dbg
  );

  modport slave (
    input  serial_in, bit_valid, dir, word_ready,
    output Q, word_valid, parity_error, frame_error, overrun, busy, state_dbg
  );
endinterface

// File: rtl/receptor_serie.sv
// receptor_serie: serial-to-parallel frame receiver.
// A frame is a start bit (0), DATA_W data bits, an optional even-parity bit and
// a stop bit (1). serial_in is sampled only on bit_valid cycles. The assembled
// word is presented on a valid/ready port.
// Optional feature macro: PARITY_CHECK_EN. When it is defined, the frame
// includes the parity bit and parity_error is live. When it is not defined,
// parity_error is tied to 0.
`timescale 1ns/1ps
module receptor_serie #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  receptor_serie_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              complete;
  logic              ferr;

  logic [DATA_W-1:0] q_q;
  logic              wv_q;
  logic              fe_q;
  logic              ov_q;

`ifdef PARITY_CHECK_EN
  // Parity mismatch of the frame in flight, and the flag held with Q.
  logic              perr_q, perr_d;
  logic              pe_q;
`endif

  // Next-state logic. Nothing advances on cycles where bit_valid is 0.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    complete = 1'b0;
    ferr     = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d   = perr_q;
`endif
    if (bus.bit_valid) begin
      case (state_q)
        IDLE: begin
          if (!bus.serial_in) begin
            dir_d   = bus.dir;
            cnt_d   = '0;
            state_d = DATA;
`ifdef PARITY_CHECK_EN
            perr_d  = 1'b0;
`endif
          end
        end
        DATA: begin
          // When dir is 0, data is sent MSB first and enters at bit 0.
          // When dir is 1, data is sent LSB first and enters at the top bit.
          if (dir_q) sh_d = {bus.serial_in, sh_q[DATA_W-1:1]};
          else       sh_d = {sh_q[DATA_W-2:0], bus.serial_in};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
        PAR: begin
`ifdef PARITY_CHECK_EN
          perr_d = bus.serial_in ^ (^sh_q);
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bus.serial_in) complete = 1'b1;
          else               ferr     = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, shift register and bit counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '1;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Output word register. A completed word is loaded only if the slot is free
  // or is being emptied in the same cycle. Otherwise the word is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q  <= '1;
      wv_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      pe_q <= 1'b0;
`endif
    end else begin
      fe_q <= ferr;
      ov_q <= 1'b0;
      if (complete) begin
        if (!wv_q || bus.word_ready) begin
          q_q  <= sh_q;
          wv_q <= 1'b1;
`ifdef PARITY_CHECK_EN
          pe_q <= perr_q;
`endif
        end else begin
          ov_q <= 1'b1;
        end
      end else if (wv_q && bus.word_ready) begin
        wv_q <= 1'b0;
      end
    end
  end

  assign bus.Q           = q_q;
  assign bus.word_valid  = wv_q;
  assign bus.frame_error = fe_q;
  assign bus.overrun     = ov_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.state_dbg   = state_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_error = pe_q;
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_serie.sv
// tb_receptor_serie: randomized bench for receptor_serie. A frame-level
// reference model predicts the output word, word_valid, frame_error,
// overrun and parity_error.
// Inputs change on the falling edge. Outputs are sampled on the next falling edge.
`timescale 1ns/1ps
module tb_receptor_serie;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Clock and reset.
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  receptor_serie_if bus();

  receptor_serie dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Scoreboard state.
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       exp_valid;
  logic [7:0] exp_word;
  logic       exp_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: apply one strobed bit, then move to the next falling edge.
  // dir is changed randomly on every bit except the start bit, because the
  // receiver must use only the value it latched with the start bit.
  task automatic drive_bit(input logic b, input logic first, input logic d, input logic rdy);
    bus.serial_in  = b;
    bus.bit_valid  = 1'b1;
    bus.dir        = first ? d : 1'($urandom);
    bus.word_ready = rdy;
    @(negedge clock);
  endtask

  // Driver: idle cycles inside a frame. The line carries random values that the
  // receiver must ignore.
  task automatic gap(input int n);
    repeat (n) begin
      bus.bit_valid  = 1'b0;
      bus.serial_in  = 1'($urandom);
      bus.dir        = 1'($urandom);
      bus.word_ready = 1'b0;
      @(negedge clock);
      check("busy_gap", 32'(bus.busy), 32'd1);
    end
  endtask

  // Send one frame and check the result one cycle after the stop-bit sample.
  // If tail is 0, the next frame can start on the very next strobe.
  task automatic send_frame(input logic [7:0] data, input logic d, input logic stop,
                            input logic par_ok, input int max_gap, input logic rdy,
                            input logic tail);
    logic [7:0] w;
    logic       fe_e;
    logic       ov_e;
    exp_q.push_back(data);
    drive_bit(1'b0, 1'b1, d, 1'b0);
    check("busy_start", 32'(bus.busy), 32'd1);
    gap($urandom_range(max_gap, 0));
    for (int i = 0; i < 8; i++) begin
      drive_bit(d ? data[i] : data[7-i], 1'b0, d, 1'b0);
      check("busy_data", 32'(bus.busy), 32'd1);
      gap($urandom_range(max_gap, 0));
    end
`ifdef PARITY_CHECK_EN
    drive_bit(par_ok ? ^data : ~^data, 1'b0, d, 1'b0);
    check("busy_par", 32'(bus.busy), 32'd1);
    gap($urandom_range(max_gap, 0));
`endif
    drive_bit(stop, 1'b0, d, rdy);
    // Reference model for the frame outcome.
    w    = exp_q.pop_front();
    fe_e = !stop;
    ov_e = 1'b0;
    if (stop) begin
      if (!exp_valid || rdy) begin
        exp_valid = 1'b1;
        exp_word  = w;
        exp_perr  = PAR_EN && !par_ok;
      end else begin
        ov_e = 1'b1;
      end
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    check("busy_end", 32'(bus.busy), 32'd0);
    check("word_valid", 32'(bus.word_valid), 32'(exp_valid));
    check("q", 32'(bus.Q), 32'(exp_word));
    check("frame_error", 32'(bus.frame_error), 32'(fe_e));
    check("overrun", 32'(bus.overrun), 32'(ov_e));
    if (exp_valid) check("parity_error", 32'(bus.parity_error), 32'(exp_perr));
    if (tail) begin
      bus.bit_valid  = 1'b0;
      bus.word_ready = 1'b0;
      bus.serial_in  = 1'b1;
      @(negedge clock);
      check("frame_error_pulse", 32'(bus.frame_error), 32'd0);
      check("overrun_pulse", 32'(bus.overrun), 32'd0);
      check("word_valid_hold", 32'(bus.word_valid), 32'(exp_valid));
    end
  endtask

  // Driver: hold word_ready for one cycle so the consumer takes the word.
  task automatic consume();
    bus.bit_valid  = 1'b0;
    bus.serial_in  = 1'b1;
    bus.word_ready = 1'b1;
    @(negedge clock);
    bus.word_ready = 1'b0;
    exp_valid = 1'b0;
    check("consume_wv", 32'(bus.word_valid), 32'd0);
  endtask

  // Send a start bit and the first four data bits, then assert reset.
  task automatic reset_mid_frame(input logic [7:0] data);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(data[7-i], 1'b0, 1'b0, 1'b0);
    bus.bit_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_valid = 1'b0;
    exp_word  = 8'hFF;
    exp_perr  = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_q", 32'(bus.Q), 32'hFF);
    check("rst_wv", 32'(bus.word_valid), 32'd0);
  endtask

  // Watchdog. The stimulus is a fixed number of cycles, so this only catches a
  // bench that has stalled.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.serial_in  = 1'b1;
    bus.bit_valid  = 1'b0;
    bus.dir        = 1'b0;
    bus.word_ready = 1'b0;
    exp_valid      = 1'b0;
    exp_word       = 8'hFF;
    exp_perr       = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_q", 32'(bus.Q), 32'hFF);
    check("reset_wv", 32'(bus.word_valid), 32'd0);
    check("reset_pe", 32'(bus.parity_error), 32'd0);
    check("reset_fe", 32'(bus.frame_error), 32'd0);
    check("reset_ov", 32'(bus.overrun), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // MSB-first and LSB-first frames carrying the same palindromic byte.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();
    // A non-palindromic byte, so that swapping the bit order changes the result.
    send_frame(8'h1E, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();

    // Bad stop bit, then a normal frame.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();

    // Overrun: the held word stays on Q. A consume on the completion cycle
    // lets the new word through.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1);
    consume();

    // Strobe gaps inside the frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b1);
    consume();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b1);
    consume();

    // Reset in the middle of a frame, with a word already held on Q.
    send_frame(8'h42, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    reset_mid_frame(8'h96);
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();

    // Parity good and bad. In the default build these are plain frames.
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    consume();

    // Back-to-back frames with no idle strobe between them.
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    send_frame(8'h56, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    consume();

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), 1'($urandom), ($urandom_range(7, 0) != 0),
                 1'($urandom), 3, 1'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) consume();
    end
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
